mp_add_seq: RTL and testbench

Multi-precision add sequencer that time-multiplexes a single 16-bit Brent-Kung carry-lookahead adder (`bk_16_cla_4`) to add operands of `WORDS` × 16 bits. Operands are captured with a valid/ready handshake. One 16-bit slice is fed to the adder per cycle, least-significant slice first, and the carry is chained through a register. The full result is presented with a valid/ready handshake. This is the sequencing front end that lets PPA comparisons of the 16-bit adder scale to wide-operand workloads without replicating the adder.

---
 rtl/mp_add_seq.sv | 165 ++++++++++++++++
 tb/tb_mp_add_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one 16-bit Brent-Kung adder walks WORDS slices, LSB slice first.
// Optional subtract mode is built when MP_ADD_SUB_EN is defined (adds the op port).

module bk_16_cla_4 (
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] p0;
  logic [15:0] g;
  logic [15:0] p;

  // Prefix tree is evaluated in place: g[i] ends up as the carry out of bit i,
  // with cin folded into bit 0 so every prefix already includes it.
  always_comb begin
    p0   = x1 ^ x2;
    g    = x1 & x2;
    p    = p0;
    g[0] = g[0] | (p[0] & cin);
    // Up-sweep: spans 2, 4, 8, 16 at the odd-aligned tree nodes.
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          g[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p[i] = p[i] & p[i - (1 << l)];
        end
      end
    end
    // Down-sweep fills in the remaining prefixes.
    for (int l = 2; l >= 0; l--) begin
      for (int i = 0; i < 16; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        end
      end
    end
    s    = p0 ^ {g[14:0], cin};
    cout = g[15];
  end

endmodule

// valid/ready: a transfer occurs on a rising clk edge where valid and ready are both
// high; in_ready and out_valid come from registered state only.
module mp_add_seq #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
`ifdef MP_ADD_SUB_EN
  input  logic                   op,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic [1:0]             state_dbg
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [WIDTH*WORDS-1:0] a_q;
  logic [WIDTH*WORDS-1:0] b_q;
  logic                   carry_q;
  logic [IDXW-1:0]        idx_q;
  logic [15:0]            x1;
  logic [15:0]            x2;
  logic [15:0]            s_slice;
  logic                   c_slice;

  assign x1 = a_q[idx_q*WIDTH +: WIDTH];

`ifdef MP_ADD_SUB_EN
  logic op_q;
  assign x2 = op_q ? ~b_q[idx_q*WIDTH +: WIDTH] : b_q[idx_q*WIDTH +: WIDTH];
`else
  assign x2 = b_q[idx_q*WIDTH +: WIDTH];
`endif

  bk_16_cla_4 u_add (
    .x1   (x1),
    .x2   (x2),
    .cin  (carry_q),
    .s    (s_slice),
    .cout (c_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef MP_ADD_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx_q <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef MP_ADD_SUB_EN
            op_q    <= op;
            // Two's-complement subtract: invert B and seed a carry of one.
            carry_q <= op ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          sum[idx_q*WIDTH +: WIDTH] <= s_slice;
          carry_q                   <= c_slice;
          if (idx_q == LAST) cout  <= c_slice;
          else               idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: a wide-integer model feeds an expected queue,
// and a negedge monitor compares every cycle the result is presented.

module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int DW    = 16 * WORDS;
  localparam int W     = DW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
`ifdef MP_ADD_SUB_EN
  logic          op;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          cout;
  logic [1:0]    state_dbg;

  mp_add_seq #(.WIDTH(16), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MP_ADD_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            due_q[$];
  int            acc_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] got_sum;
  logic          got_cout;
  logic          prev_ov = 1'b0;
  logic          ready_next_chk = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                         input logic mcin, input logic msub);
    if (msub) return {1'b0, ma} + {1'b0, ~mb} + W'(1);
    return {1'b0, ma} + {1'b0, mb} + W'(mcin);
  endfunction

  // ---------------- monitor / compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_ov        = 1'b0;
      ready_next_chk = 1'b0;
    end else begin
      if (ready_next_chk) begin
        check("ready_after_release", W'(in_ready), W'(1));
        ready_next_chk = 1'b0;
      end
      if (out_valid) begin
        check("ready_low_in_done", W'(in_ready), W'(0));
        if (exp_q.size() == 0) begin
          check("spurious_valid", W'(out_valid), W'(0));
        end else begin
          if (!prev_ov && due_q.size() != 0) check("latency", W'(cyc), W'(due_q.pop_front()));
          check("result", {cout, sum}, exp_q[0]);
          if (out_ready) begin
            got_sum        = sum;
            got_cout       = cout;
            void'(exp_q.pop_front());
            ready_next_chk = 1'b1;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic submit(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic tcin,
                        input logic tsub);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", W'(in_ready), W'(1));
      return;
    end
    a        = ta;
    b        = tb_;
    cin      = tcin;
`ifdef MP_ADD_SUB_EN
    op       = tsub;
`endif
    in_valid = 1'b1;
    exp_q.push_back(model(ta, tb_, tcin, tsub));
    due_q.push_back(cyc + 1 + WORDS);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), W'(0));
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int a0;
    int a1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
`ifdef MP_ADD_SUB_EN
    op        = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_sum", W'(sum), W'(0));
    check("reset_cout", W'(cout), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Carry ripples through every slice and out of the top.
    submit(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    drain();
    check("t1_sum", W'(got_sum), W'(0));
    check("t1_cout", W'(got_cout), W'(1));

    // Carry crosses the slice 0->1 boundary only.
    submit(64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 1'b0);
    drain();
    check("t2_sum", W'(got_sum), W'(64'h0000_FFFF_0001_0000));
    check("t2_cout", W'(got_cout), W'(0));

    // Mixed pattern plus cin chaining to a full wrap.
    submit(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    drain();
    check("t3_sum", W'(got_sum), W'(0));
    check("t3_cout", W'(got_cout), W'(1));

    // Back-pressure: result held, extra requests ignored.
    out_ready = 1'b0;
    submit(64'h0, 64'h0, 1'b1, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("hold_reach_done", W'(out_valid), W'(1));
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a        = {$urandom(), $urandom()};
      b        = {$urandom(), $urandom()};
      cin      = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_sum", W'(sum), W'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("t4_sum", W'(got_sum), W'(1));
    check("t4_cout", W'(got_cout), W'(0));
    repeat (8) @(posedge clk);
    #1;
    check("t4_no_extra", W'(out_valid), W'(0));

    // Abort mid-RUN with idx at 2.
    submit(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_sum", W'(sum), W'(0));
    check("abort_cout", W'(cout), W'(0));
    check("abort_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    submit(64'h3, 64'h4, 1'b0, 1'b0);
    drain();
    check("t5_sum", W'(got_sum), W'(7));
    check("t5_cout", W'(got_cout), W'(0));

    // Back-to-back with out_ready held high.
    acc_q.delete();
    submit(64'h1234, 64'h1111, 1'b0, 1'b0);
    submit(64'hFFFF, 64'h0001, 1'b0, 1'b0);
    a0 = acc_q[0];
    a1 = acc_q[1];
    check("accept_spacing", W'(a1 - a0), W'(WORDS + 2));
    drain();
    check("t6_sum", W'(got_sum), W'(64'h1_0000));
    check("t6_cout", W'(got_cout), W'(0));

`ifdef MP_ADD_SUB_EN
    submit(64'h5, 64'h7, 1'b0, 1'b1);
    drain();
    check("sub1_sum", W'(got_sum), W'(64'hFFFF_FFFF_FFFF_FFFE));
    check("sub1_cout", W'(got_cout), W'(0));
    submit(64'h7, 64'h5, 1'b0, 1'b1);
    drain();
    check("sub2_sum", W'(got_sum), W'(2));
    check("sub2_cout", W'(got_cout), W'(1));
`endif

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
